switch_encoder_8to3: RTL and testbench
======================================

// Module: switch_encoder_8to3
// PURPOSE
//   Input-side counterpart of the 3-to-8 LED decoder path: reads 8 bouncy board switches and produces a 3-bit number.
//   Synchronises, debounces and priority-encodes the switch vector. Emits a 1-cycle change strobe when the number changes.
//   Sits between the board pins and counter/display logic. Drives a 3-bit value, the same width the LED decoder consumes.
// PARAMETERS
//   DEBOUNCE_CYCLES  50000  consecutive identical synced samples needed to accept a new vector; legal range >= 1
//   PRIORITY_HIGH    1      1: highest set bit wins; 0: lowest set bit wins
// PORTS
//   clock      in   1  system clock; all logic on posedge
//   reset      in   1  synchronous, active-high reset
//   switches   in   8  raw asynchronous switch levels, bit i = switch i
//   value      out  3  encoded index of the winning set bit of sw_stable
//   valid      out  1  1 when sw_stable != 0
//   multi      out  1  1 when more than one bit of sw_stable is set
//   change     out  1  1-cycle pulse when {valid,value} differs from its previous registered value
//   sw_stable  out  8  debounced switch vector
// BEHAVIOUR
//   Reset (sampled on posedge while reset=1):
//     - Clears sync1, sync2, cand, cnt, sw_stable, value, valid, multi and change to 0.
//     - Reset dominates every other event. A debounce in progress is discarded.
//   Synchroniser: sync1 <= switches; sync2 <= sync1.
//   Candidate register: cand <= sync2 every cycle.
//   Debounce counter cnt:
//     - Width max(1, $clog2(DEBOUNCE_CYCLES)).
//     - If sync2 == sw_stable or sync2 != cand: cnt <= 0. This covers no change, and a bounce or a new pattern mid-count.
//     - Else if cnt == DEBOUNCE_CYCLES-1: sw_stable <= sync2; cnt <= 0.
//     - Else cnt <= cnt + 1.
//     - cnt never wraps: it is cleared on acceptance.
//   Encoder (registered from sw_stable, one cycle after sw_stable updates):
//     - valid <= |sw_stable.
//     - multi <= popcount(sw_stable) > 1.
//     - value <= index of the highest set bit (PRIORITY_HIGH=1) or the lowest set bit (0).
//     - value <= 0 when sw_stable == 0.
//   change <= ({valid,value} next != {valid,value} current). Registered with the encoder; high for exactly 1 cycle.
//     - A change in multi alone does not pulse change.
//     - A sw_stable change that leaves the winning bit unchanged does not pulse change.
//   Latency:
//     - switches changes and is held, first sampled at edge 1.
//     - sw_stable updates at edge DEBOUNCE_CYCLES+3.
//     - value, valid, multi and change update at edge DEBOUNCE_CYCLES+4.
//   Boundaries:
//     - Any sync2 toggle restarts the count.
//     - Simultaneous multi-bit changes are accepted as one vector.
//     - Switches held non-zero through reset appear N+4 cycles after release, with a change pulse.
//     - DEBOUNCE_CYCLES=1 accepts after 2 equal synced samples.
// TESTING (DEBOUNCE_CYCLES=4, so latency is 8 edges)
//   1. reset=1 for 3 cycles, switches=0x00, then release
//      -> value=0, valid=0, multi=0, change=0, sw_stable=0x00 on every cycle.
//   2. switches 0x00->0x08 held
//      -> sw_stable=0x08 at edge 7; value=3, valid=1, multi=0 at edge 8; change=1 only at edge 8.
//   3. switches toggle 0x08<->0x00 every 2 cycles for 12 cycles, then held at 0x00
//      -> no output change until 8 edges after the last toggle; then valid=0, value=0 and a single change pulse.
//   4. switches=0x81: PRIORITY_HIGH=1 -> value=7, multi=1; PRIORITY_HIGH=0 -> value=0, multi=1; each with 1 change pulse.
//   5. Stable at 0x08, then switches=0x0C (PRIORITY_HIGH=1)
//      -> sw_stable=0x0C, multi rises to 1, value stays 3, change stays 0.
//   6. switches=0x20 held, reset pulsed for 1 cycle at edge 5
//      -> all outputs 0 after reset; value=5, valid=1 and the change pulse arrive 8 edges after reset release.

Source files
------------

// File: rtl/switch_encoder_8to3.sv
// Board switch front end: two-flop synchroniser, debounce, then a registered
// 8-to-3 priority encoder with a one-cycle strobe whenever {valid,value} changes.
module switch_encoder_8to3 #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit PRIORITY_HIGH   = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] switches,
  output logic [2:0] value,
  output logic       valid,
  output logic       multi,
  output logic       change,
  output logic [7:0] sw_stable
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [7:0]    sync1, sync2, cand;
  logic [CW-1:0] cnt;
  logic [2:0]    enc_val;
  logic          enc_vld;
  logic [3:0]    ones;

  always_comb begin
    enc_val = '0;
    ones    = '0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < 8; i++)
        if (sw_stable[i]) enc_val = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (sw_stable[i]) enc_val = 3'(i);
    end
    for (int i = 0; i < 8; i++)
      ones = ones + 4'(sw_stable[i]);
    enc_vld = |sw_stable;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      cand      <= '0;
      cnt       <= '0;
      sw_stable <= '0;
      value     <= '0;
      valid     <= 1'b0;
      multi     <= 1'b0;
      change    <= 1'b0;
    end else begin
      sync1 <= switches;
      sync2 <= sync1;
      cand  <= sync2;
      // Any movement of the synced vector, or no pending difference, restarts the count.
      if (sync2 == sw_stable || sync2 != cand) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        sw_stable <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      valid  <= enc_vld;
      value  <= enc_val;
      multi  <= (ones > 4'd1);
      change <= ({enc_vld, enc_val} != {valid, value});
    end
  end
endmodule

// File: tb/tb_switch_encoder_8to3.sv
// Randomised + directed bench for switch_encoder_8to3: three instances (two
// priorities, two debounce lengths) against a run-length reference model.
module tb_switch_encoder_8to3;
  typedef logic [2:0][13:0] obs3_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] switches = '0;

  logic [2:0] value0, value1, value2;
  logic       valid0, valid1, valid2, multi0, multi1, multi2, change0, change1, change2;
  logic [7:0] stab0, stab1, stab2;
  obs3_t      act;

  always #5 clock = ~clock;

  switch_encoder_8to3 #(.DEBOUNCE_CYCLES(4), .PRIORITY_HIGH(1'b1)) u_hi (
    .clock(clock), .reset(reset), .switches(switches), .value(value0), .valid(valid0),
    .multi(multi0), .change(change0), .sw_stable(stab0));
  switch_encoder_8to3 #(.DEBOUNCE_CYCLES(4), .PRIORITY_HIGH(1'b0)) u_lo (
    .clock(clock), .reset(reset), .switches(switches), .value(value1), .valid(valid1),
    .multi(multi1), .change(change1), .sw_stable(stab1));
  switch_encoder_8to3 #(.DEBOUNCE_CYCLES(1), .PRIORITY_HIGH(1'b1)) u_n1 (
    .clock(clock), .reset(reset), .switches(switches), .value(value2), .valid(valid2),
    .multi(multi2), .change(change2), .sw_stable(stab2));

  assign act[0] = {stab0, value0, valid0, multi0, change0};
  assign act[1] = {stab1, value1, valid1, multi1, change1};
  assign act[2] = {stab2, value2, valid2, multi2, change2};

  // Reference model: a vector is accepted once the synced input has shown the
  // same value on DEBOUNCE_CYCLES+1 consecutive edges and it differs from the stable one.
  int         n_cfg [3] = '{4, 4, 1};
  bit         hi_cfg[3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0] m_s1[3], m_s2[3], m_prev[3], m_stab[3];
  int         m_run[3];
  logic [2:0] m_val[3];
  logic       m_vld[3], m_mul[3], m_chg[3];

  obs3_t exp_q[$];
  int    n_vec = 0, n_err = 0, edge_no = 0;

  function automatic logic [2:0] winner(input logic [7:0] x, input bit hi);
    int v;
    v = int'(x);
    if (v == 0) return 3'd0;
    if (hi) return 3'($clog2(v + 1) - 1);
    return 3'($clog2(v & (-v)));
  endfunction

  task automatic model_edge(input logic [7:0] sw, input logic r);
    obs3_t e;
    logic [2:0] nv;
    logic nd;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        m_s1[k] = '0; m_s2[k] = '0; m_prev[k] = '0; m_run[k] = 1; m_stab[k] = '0;
        m_val[k] = '0; m_vld[k] = 1'b0; m_mul[k] = 1'b0; m_chg[k] = 1'b0;
      end else begin
        nd = (m_stab[k] != 8'h00);
        nv = winner(m_stab[k], hi_cfg[k]);
        m_chg[k] = ({nd, nv} != {m_vld[k], m_val[k]});
        m_vld[k] = nd;
        m_val[k] = nv;
        m_mul[k] = ($countones(m_stab[k]) > 1);
        if (m_s2[k] == m_prev[k]) m_run[k] = (m_run[k] < 1000) ? m_run[k] + 1 : m_run[k];
        else m_run[k] = 1;
        m_prev[k] = m_s2[k];
        if (m_run[k] >= n_cfg[k] + 1 && m_s2[k] != m_stab[k]) m_stab[k] = m_s2[k];
        m_s2[k] = m_s1[k];
        m_s1[k] = sw;
      end
      e[k] = {m_stab[k], m_val[k], m_vld[k], m_mul[k], m_chg[k]};
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [7:0] sw, input logic r);
    @(negedge clock);
    switches = sw;
    reset    = r;
    @(posedge clock);
    edge_no++;
    model_edge(sw, r);
  endtask

  task automatic hold(input logic [7:0] sw, input int n);
    for (int i = 0; i < n; i++) step(sw, 1'b0);
  endtask

  // Monitor: every cycle the registered outputs are presented; pop and compare.
  always @(negedge clock) begin
    obs3_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (act[k] !== e[k]) begin
          n_err++;
          $display("FAIL dut%0d edge %0d: got stab=%h val=%0d vld=%b mul=%b chg=%b, want stab=%h val=%0d vld=%b mul=%b chg=%b",
                   k, edge_no, act[k][13:6], act[k][5:3], act[k][2], act[k][1], act[k][0],
                   e[k][13:6], e[k][5:3], e[k][2], e[k][1], e[k][0]);
        end
      end
    end
  end

  initial begin
    logic [7:0] v;
    int sel;
    for (int k = 0; k < 3; k++) begin
      m_s1[k] = '0; m_s2[k] = '0; m_prev[k] = '0; m_run[k] = 1; m_stab[k] = '0;
      m_val[k] = '0; m_vld[k] = 1'b0; m_mul[k] = 1'b0; m_chg[k] = 1'b0;
    end
    // Reset then quiet
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1);
    hold(8'h00, 6);
    // Single switch
    hold(8'h08, 12);
    // Bounce between 0x08 and 0x00, then settle low
    for (int i = 0; i < 6; i++) begin
      hold(8'h00, 2);
      hold(8'h08, 2);
    end
    hold(8'h00, 12);
    // Two switches at opposite ends
    hold(8'h81, 12);
    // Extra lower bit that does not move the winner
    hold(8'h08, 12);
    hold(8'h0C, 12);
    // Held switch through a mid-debounce reset
    hold(8'h00, 12);
    hold(8'h20, 4);
    step(8'h20, 1'b1);
    hold(8'h20, 12);
    // Random patterns, hold lengths and occasional resets
    for (int s = 0; s < 300; s++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: v = 8'h00;
        1: v = 8'h01 << $urandom_range(0, 7);
        default: v = 8'($urandom);
      endcase
      if ($urandom_range(0, 39) == 0) step(v, 1'b1);
      hold(v, int'($urandom_range(1, 10)));
    end
    hold(8'h00, 10);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
